// File: rtl/control_sequencer.sv
// Hardwired Mini SRC control unit: fetch T0-T2, execute T3-T6. Strobes decode combinationally from state/opcode.
// Stalls in T1 until mem_ready; after WAIT_MAX idle T1 cycles it raises sticky mem_fault and halts.
module control_sequencer #(
   parameter int OPW      = 5,
   parameter int WAIT_MAX = 15
) (
   input  logic           clk,
   input  logic           clr,
   input  logic [31:0]    ir,
   input  logic           mem_ready,
   input  logic           stop,
   output logic           PC_out,
   output logic           Zlow_out,
   output logic           Zhigh_out,
   output logic           MDR_out,
   output logic           MAR_in,
   output logic           MDR_in,
   output logic           PC_in,
   output logic           IR_in,
   output logic           Y_in,
   output logic           Z_in,
   output logic           HI_in,
   output logic           LO_in,
   output logic           Read,
   output logic           IncPC,
   output logic           Gra,
   output logic           Grb,
   output logic           Grc,
   output logic           R_in,
   output logic           R_out,
   output logic [OPW-1:0] alu_instruction,
   output logic           run,
   output logic           illegal,
   output logic           mem_fault
);

   typedef enum logic [3:0] {
      S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALTED
   } state_t;

   localparam int CW = $clog2(WAIT_MAX + 1);

   state_t         state, state_nxt;
   logic [CW-1:0]  cnt, cnt_nxt;
   logic           fault_nxt;
   logic           ins_end;
   logic [OPW-1:0] op;
   logic           is_bin, is_md, is_un, is_nop, is_halt;
   logic           unused_ir_bits;

   assign op             = ir[31 -: OPW];
   assign unused_ir_bits = ^ir[31-OPW:0];

   assign is_bin  = (op >= OPW'(3)) && (op <= OPW'(11));
   assign is_md   = (op == OPW'(15)) || (op == OPW'(16));
   assign is_un   = (op == OPW'(17)) || (op == OPW'(18));
   assign is_nop  = (op == OPW'(26));
   assign is_halt = (op == OPW'(27));

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state     <= S_RST;
         cnt       <= '0;
         mem_fault <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         mem_fault <= fault_nxt;
      end
   end

   always_comb begin
      state_nxt       = state;
      cnt_nxt         = cnt;
      fault_nxt       = mem_fault;
      ins_end         = 1'b0;
      PC_out          = 1'b0;
      Zlow_out        = 1'b0;
      Zhigh_out       = 1'b0;
      MDR_out         = 1'b0;
      MAR_in          = 1'b0;
      MDR_in          = 1'b0;
      PC_in           = 1'b0;
      IR_in           = 1'b0;
      Y_in            = 1'b0;
      Z_in            = 1'b0;
      HI_in           = 1'b0;
      LO_in           = 1'b0;
      Read            = 1'b0;
      IncPC           = 1'b0;
      Gra             = 1'b0;
      Grb             = 1'b0;
      Grc             = 1'b0;
      R_in            = 1'b0;
      R_out           = 1'b0;
      alu_instruction = '0;
      run             = 1'b0;
      illegal         = 1'b0;

      case (state)
         S_RST: state_nxt = S_T0;
         S_T0: begin
            run       = 1'b1;
            PC_out    = 1'b1;
            MAR_in    = 1'b1;
            IncPC     = 1'b1;
            Z_in      = 1'b1;
            state_nxt = S_T1;
         end
         S_T1: begin
            // Strobes stay up every wait cycle; Zlow holds PC+1 so reloading PC is harmless.
            run      = 1'b1;
            Zlow_out = 1'b1;
            PC_in    = 1'b1;
            Read     = 1'b1;
            MDR_in   = 1'b1;
            if (mem_ready) begin
               cnt_nxt   = '0;
               state_nxt = S_T2;
            end else if (cnt == CW'(WAIT_MAX - 1)) begin
               cnt_nxt   = '0;
               fault_nxt = 1'b1;
               state_nxt = S_HALTED;
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         S_T2: begin
            run       = 1'b1;
            MDR_out   = 1'b1;
            IR_in     = 1'b1;
            state_nxt = S_T3;
         end
         S_T3: begin
            run = 1'b1;
            if (is_bin || is_md) begin
               Grb       = 1'b1;
               R_out     = 1'b1;
               Y_in      = 1'b1;
               state_nxt = S_T4;
            end else if (is_un) begin
               Grb             = 1'b1;
               R_out           = 1'b1;
               alu_instruction = op;
               Z_in            = 1'b1;
               state_nxt       = S_T4;
            end else if (is_halt) begin
               state_nxt = S_HALTED;
            end else if (is_nop) begin
               ins_end = 1'b1;
            end else begin
               illegal = 1'b1;
               ins_end = 1'b1;
            end
         end
         S_T4: begin
            run = 1'b1;
            if (is_un) begin
               Zlow_out = 1'b1;
               Gra      = 1'b1;
               R_in     = 1'b1;
               ins_end  = 1'b1;
            end else begin
               Grc             = 1'b1;
               R_out           = 1'b1;
               alu_instruction = op;
               Z_in            = 1'b1;
               state_nxt       = S_T5;
            end
         end
         S_T5: begin
            run      = 1'b1;
            Zlow_out = 1'b1;
            if (is_md) begin
               LO_in     = 1'b1;
               state_nxt = S_T6;
            end else begin
               Gra     = 1'b1;
               R_in    = 1'b1;
               ins_end = 1'b1;
            end
         end
         S_T6: begin
            run       = 1'b1;
            Zhigh_out = 1'b1;
            HI_in     = 1'b1;
            ins_end   = 1'b1;
         end
         S_HALTED: state_nxt = S_HALTED;
         default:  state_nxt = S_RST;
      endcase

      // stop is honoured only at an instruction boundary.
      if (ins_end) state_nxt = stop ? S_HALTED : S_T0;
   end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: per-cycle expected strobe vectors are queued with the
// inputs to drive, then popped and compared against the DUT on each falling edge.
module tb_control_sequencer;

   logic        clk, clr, mem_ready, stop;
   logic [31:0] ir;
   logic        PC_out, Zlow_out, Zhigh_out, MDR_out, MAR_in, MDR_in, PC_in, IR_in;
   logic        Y_in, Z_in, HI_in, LO_in, Read, IncPC, Gra, Grb, Grc, R_in, R_out;
   logic [4:0]  alu_instruction;
   logic        run, illegal, mem_fault;
   logic [21:0] obs;

   int tests = 0;
   int fails = 0;

   localparam logic [21:0] M_PCO  = 22'h000001, M_ZLO  = 22'h000002, M_ZHI = 22'h000004;
   localparam logic [21:0] M_MDRO = 22'h000008, M_MAR  = 22'h000010, M_MDRI = 22'h000020;
   localparam logic [21:0] M_PCI  = 22'h000040, M_IRI  = 22'h000080, M_Y = 22'h000100;
   localparam logic [21:0] M_Z    = 22'h000200, M_HI   = 22'h000400, M_LO = 22'h000800;
   localparam logic [21:0] M_RD   = 22'h001000, M_INC  = 22'h002000, M_GRA = 22'h004000;
   localparam logic [21:0] M_GRB  = 22'h008000, M_GRC  = 22'h010000, M_RIN = 22'h020000;
   localparam logic [21:0] M_ROUT = 22'h040000, M_RUN  = 22'h080000, M_ILL = 22'h100000;
   localparam logic [21:0] M_FLT  = 22'h200000;

   typedef struct {
      logic [21:0] s;
      logic [4:0]  alu;
      logic        mr;
      logic        st;
      logic [31:0] ir;
      string       tag;
   } exp_t;

   exp_t        q[$];
   logic        exp_fault = 1'b0;
   logic [31:0] cur_ir = 32'h0;

   control_sequencer dut (
      .clk(clk), .clr(clr), .ir(ir), .mem_ready(mem_ready), .stop(stop),
      .PC_out(PC_out), .Zlow_out(Zlow_out), .Zhigh_out(Zhigh_out), .MDR_out(MDR_out),
      .MAR_in(MAR_in), .MDR_in(MDR_in), .PC_in(PC_in), .IR_in(IR_in), .Y_in(Y_in),
      .Z_in(Z_in), .HI_in(HI_in), .LO_in(LO_in), .Read(Read), .IncPC(IncPC),
      .Gra(Gra), .Grb(Grb), .Grc(Grc), .R_in(R_in), .R_out(R_out),
      .alu_instruction(alu_instruction), .run(run), .illegal(illegal), .mem_fault(mem_fault)
   );

   assign obs = {mem_fault, illegal, run, R_out, R_in, Grc, Grb, Gra, IncPC, Read, LO_in, HI_in,
                 Z_in, Y_in, IR_in, PC_in, MDR_in, MAR_in, MDR_out, Zhigh_out, Zlow_out, PC_out};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic push(input logic [21:0] s, input logic [4:0] alu, input logic mr,
                       input logic st, input string tag);
      exp_t e;
      e.s   = s | (exp_fault ? M_FLT : 22'h0);
      e.alu = alu;
      e.mr  = mr;
      e.st  = st;
      e.ir  = cur_ir;
      e.tag = tag;
      q.push_back(e);
   endtask

   // Each entry is one state: ir changes just after the edge entering it, outputs are
   // checked on the falling edge, then mem_ready/stop are set for the edge leaving it.
   task automatic drain();
      exp_t e;
      while (q.size() > 0) begin
         e = q.pop_front();
         @(posedge clk);
         #1 ir = e.ir;
         @(negedge clk);
         tests++;
         if (obs !== e.s || alu_instruction !== e.alu) begin
            fails++;
            $display("FAIL %s: got strobes=%h alu=%0d, expected strobes=%h alu=%0d",
                     e.tag, obs, alu_instruction, e.s, e.alu);
         end
         mem_ready = e.mr;
         stop      = e.st;
      end
   endtask

   task automatic queue_instr(input logic [31:0] instr, input int waits,
                              input logic st_early, input logic st_end);
      logic [4:0] op;
      logic       bin, md, un;
      op     = instr[31:27];
      cur_ir = instr;
      bin    = (op >= 5'd3) && (op <= 5'd11);
      md     = (op == 5'd15) || (op == 5'd16);
      un     = (op == 5'd17) || (op == 5'd18);
      push(M_RUN | M_PCO | M_MAR | M_INC | M_Z, 5'd0, 1'b0, st_early, "T0");
      for (int i = 0; i < waits; i++)
         push(M_RUN | M_ZLO | M_PCI | M_RD | M_MDRI, 5'd0, 1'b0, st_early, "T1_wait");
      push(M_RUN | M_ZLO | M_PCI | M_RD | M_MDRI, 5'd0, 1'b1, st_early, "T1");
      push(M_RUN | M_MDRO | M_IRI, 5'd0, 1'b0, st_early, "T2");
      if (bin || md) begin
         push(M_RUN | M_GRB | M_ROUT | M_Y, 5'd0, 1'b0, st_early, "T3_bin");
         push(M_RUN | M_GRC | M_ROUT | M_Z, op, 1'b0, st_early, "T4_bin");
         if (md) begin
            push(M_RUN | M_ZLO | M_LO, 5'd0, 1'b0, st_early, "T5_md");
            push(M_RUN | M_ZHI | M_HI, 5'd0, 1'b0, st_end, "T6_md");
         end else begin
            push(M_RUN | M_ZLO | M_GRA | M_RIN, 5'd0, 1'b0, st_end, "T5_bin");
         end
      end else if (un) begin
         push(M_RUN | M_GRB | M_ROUT | M_Z, op, 1'b0, st_early, "T3_un");
         push(M_RUN | M_ZLO | M_GRA | M_RIN, 5'd0, 1'b0, st_end, "T4_un");
      end else if (op == 5'd27) begin
         push(M_RUN, 5'd0, 1'b0, 1'b0, "T3_halt");
      end else if (op == 5'd26) begin
         push(M_RUN, 5'd0, 1'b0, st_end, "T3_nop");
      end else begin
         push(M_RUN | M_ILL, 5'd0, 1'b0, st_end, "T3_illegal");
      end
   endtask

   task automatic queue_halted(input int n);
      for (int i = 0; i < n; i++) push(22'h0, 5'd0, 1'b1, 1'b0, "HALTED");
   endtask

   // Asserts clr in the high phase, checks the asynchronous clear, releases it so the
   // next falling edge shows RST and the following state is T0.
   task automatic do_reset(input string tag);
      clr       = 1'b0;
      exp_fault = 1'b0;
      #1;
      tests++;
      if (obs !== 22'h0 || alu_instruction !== 5'd0) begin
         fails++;
         $display("FAIL %s_async: got strobes=%h alu=%0d, expected all 0", tag, obs, alu_instruction);
      end
      @(posedge clk);
      #2 clr = 1'b1;
      mem_ready = 1'b0;
      stop      = 1'b0;
      @(negedge clk);
      tests++;
      if (obs !== 22'h0 || alu_instruction !== 5'd0) begin
         fails++;
         $display("FAIL %s_rst_state: got strobes=%h alu=%0d, expected all 0", tag, obs, alu_instruction);
      end
   endtask

   task automatic test_reset();
      do_reset("reset");
   endtask

   task automatic test_abort_mid_t4();
      queue_instr(32'h18000000, 0, 1'b0, 1'b0);
      void'(q.pop_back());
      void'(q.pop_back());
      drain();
      @(posedge clk);
      #1;
      tests++;
      if (obs !== (M_RUN | M_GRC | M_ROUT | M_Z) || alu_instruction !== 5'd3) begin
         fails++;
         $display("FAIL abort_t4_pre: got strobes=%h alu=%0d, expected strobes=%h alu=3",
                  obs, alu_instruction, M_RUN | M_GRC | M_ROUT | M_Z);
      end
      #1 do_reset("abort_t4");
   endtask

   task automatic test_shr();
      queue_instr(32'h389A8000, 0, 1'b0, 1'b0);
      drain();
   endtask

   task automatic test_mul_wait();
      queue_instr(32'h78000000, 3, 1'b0, 1'b0);
      drain();
   endtask

   task automatic test_stop_ignored();
      queue_instr(32'h18000000, 0, 1'b1, 1'b0);
      drain();
   endtask

   task automatic test_back_to_back();
      queue_instr(32'hD0000000, 0, 1'b0, 1'b0);
      queue_instr(32'hF8000000, 0, 1'b0, 1'b0);
      queue_instr(32'h80000000, 1, 1'b0, 1'b0);
      queue_instr(32'h90000000, 0, 1'b0, 1'b0);
      queue_instr(32'h00000000, 0, 1'b0, 1'b0);
      drain();
   endtask

   task automatic test_neg_stop();
      queue_instr(32'h88000000, 0, 1'b0, 1'b1);
      queue_halted(3);
      drain();
      @(posedge clk);
      #2 do_reset("after_neg_stop");
   endtask

   task automatic test_mem_fault();
      cur_ir = 32'h18000000;
      push(M_RUN | M_PCO | M_MAR | M_INC | M_Z, 5'd0, 1'b0, 1'b0, "fault_T0");
      for (int i = 0; i < 15; i++)
         push(M_RUN | M_ZLO | M_PCI | M_RD | M_MDRI, 5'd0, 1'b0, 1'b0, "fault_T1");
      exp_fault = 1'b1;
      queue_halted(3);
      drain();
      @(posedge clk);
      #2 do_reset("after_fault");
   endtask

   task automatic test_halt();
      queue_instr(32'hD8000000, 0, 1'b0, 1'b0);
      queue_halted(3);
      drain();
      @(posedge clk);
      #2 do_reset("after_halt");
   endtask

   initial begin
      clr       = 1'b0;
      ir        = 32'h0;
      mem_ready = 1'b0;
      stop      = 1'b0;
      @(posedge clk);
      #2;
      test_reset();
      test_abort_mid_t4();
      test_shr();
      test_mul_wait();
      test_stop_ignored();
      test_back_to_back();
      test_neg_stop();
      test_mem_fault();
      test_halt();
      test_shr();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardwired Mini SRC control unit. It drives the datapath control strobes that were previously hand-sequenced by benches: fetch T0–T2 and execute T3–T6 for register-format ALU, mul/div, neg/not, nop and halt instructions.
- Sits beside the datapath. It reads IR_Data and the memory handshake, and emits bus-out/reg-in strobes, select lines and alu_instruction.

Parameters:
- OPW, 5, opcode width (IR[31:27]).
- WAIT_MAX, 15, maximum cycles spent in T1 waiting for mem_ready before a fault.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- clr  in  1  asynchronous active-low reset.
- ir  in  32  IR_Data from the datapath.
- mem_ready  in  1  memory read data valid on Mdatain.
- stop  in  1  request to halt at the next instruction boundary.
- PC_out, Zlow_out, Zhigh_out, MDR_out  out  1 each  bus drivers.
- MAR_in, MDR_in, PC_in, IR_in, Y_in, Z_in, HI_in, LO_in  out  1 each  register loads.
- Read, IncPC  out  1 each  memory read; ALU PC+1 mode.
- Gra, Grb, Grc, R_in, R_out  out  1 each  register-field select and general-register strobes, for the select/encode block.
- alu_instruction  out  OPW  ALU operation code.
- run  out  1  high while executing.
- illegal  out  1  one-cycle pulse on an unsupported opcode.
- mem_fault  out  1  sticky; set on a T1 timeout.

Behaviour:
- States: RST, T0, T1, T2, T3, T4, T5, T6, HALTED. The state register is reset asynchronously by clr=0.
- Reset values while clr=0:
  - State is RST.
  - All outputs are 0, including run, illegal and mem_fault.
  - The wait counter is 0.
- Reset asserted mid-instruction aborts immediately to RST with all strobes 0.
- Outputs are decoded combinationally from the state. In T3–T6 they also depend on op = ir[31:27]. Any strobe not listed for a state is 0.
- alu_instruction = 0 except in the states where it is listed below.
- RST: next state T0.
- T0: PC_out, MAR_in, IncPC, Z_in. Next state T1.
- T1: Zlow_out, PC_in, Read, MDR_in, held every cycle.
  - If mem_ready=1, next state is T2 and the counter is cleared.
  - Otherwise the counter increments. When the counter reaches WAIT_MAX with mem_ready still 0: set mem_fault, go to HALTED.
  - With mem_ready already 1 on entry, T1 lasts exactly 1 cycle. PC_in then repeats each wait cycle; the datapath tolerates this because Zlow is stable.
- T2: MDR_out, IR_in. Next state T3. IR becomes valid at the end of T2.
- Op groups:
  - Binary: 3–11 (add..rol).
  - Mul/div: 15, 16.
  - Unary: 17, 18 (neg, not).
  - nop: 26.
  - halt: 27.
  - All other opcodes are illegal.
- T3:
  - Binary and mul/div: Grb, R_out, Y_in.
  - Unary: Grb, R_out, alu_instruction=op, Z_in.
  - nop: no strobes; next state T0.
  - halt: no strobes; next state HALTED.
  - Illegal: illegal=1; next state T0.
  - Binary, mul/div and unary: next state T4.
- T4:
  - Binary and mul/div: Grc, R_out, alu_instruction=op, Z_in; next state T5.
  - Unary: Zlow_out, Gra, R_in; the instruction ends.
- T5:
  - Binary: Zlow_out, Gra, R_in; the instruction ends.
  - Mul/div: Zlow_out, LO_in; next state T6.
- T6 (mul/div only): Zhigh_out, HI_in; the instruction ends.
- Instruction end (including nop and illegal in T3): next state is T0, or HALTED if stop=1 at that edge. stop has no effect in any other state.
- HALTED: run=0, all strobes 0. Only clr leaves it.
- run = 1 in T0–T6.
- Cycle counts from T0 with zero wait: binary 6, unary 5, mul/div 7, nop 4, illegal 4.

Test Plan:
- clr pulsed low mid-T4 of an add → all outputs 0 asynchronously; RST then T0 on the first two edges after release.
- Fetch 0x389A8000 (shr R1,R3,R5), mem_ready=1 → T3: Grb, R_out, Y_in; T4: Grc, R_out, Z_in, alu_instruction=5'b00111; T5: Gra, R_in, Zlow_out; back to T0 after 6 cycles.
- mul (op 15), mem_ready delayed 3 cycles → T1 held 4 cycles with Read and MDR_in high; T5 LO_in, T6 HI_in; total 10 cycles.
- neg (op 17) with stop=1 asserted during T4 → alu_instruction=17 in T3, R_in in T4, then HALTED with run=0.
- op 31 → illegal pulses for exactly 1 cycle in T3; next state T0; no R_in or Z_in asserted.
- mem_ready stuck at 0 → after 15 T1 cycles mem_fault=1, HALTED; a halt instruction (op 27) separately reaches HALTED with mem_fault=0.
